rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (rf_we/rf_wa/rf_wd) between two writeback sources:
//  port A = in-order pipeline WB stage, port B = long-latency unit (divider / memory refill).
//  Valid/ready handshake per source; one write per cycle, registered onto the REG_FILE write port.
//  Resolves same-register WAW between sources; optional anti-starvation guard for port B.
// PARAMETERS
//  AW            5   register address width
//  DW            32  data width
//  STARVE_LIMIT  4   consecutive denied B cycles before B is forced through (guard build only; >=1)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rstn       in   1   reset, asynchronous, active-low
//  a_valid    in   1   A has a write pending
//  a_ready    out  1   A write accepted this cycle (combinational)
//  a_wa       in   AW  A destination register
//  a_wd       in   DW  A write data
//  b_valid    in   1   B has a write pending
//  b_ready    out  1   B write accepted this cycle (combinational)
//  b_wa       in   AW  B destination register
//  b_wd       in   DW  B write data
//  rf_we      out  1   to REG_FILE write enable (registered)
//  rf_wa      out  AW  to REG_FILE write address (registered)
//  rf_wd      out  DW  to REG_FILE write data (registered)
//  grant_b    out  1   registered: current rf write originated from B
//  b_starved  out  1   registered: starvation counter saturated (0 when guard compiled out)
// BEHAVIOUR
//  - Reset (rstn=0, async): rf_we=0, rf_wa=0, rf_wd=0, grant_b=0, b_starved=0, starve_cnt=0.
//    Handshakes in flight at reset are dropped; sources must re-present after release.
//  - Ready depends only on a_valid/b_valid, addresses and starve_cnt; never on rf_* outputs.
//  - Winner selection each cycle: force_b = guard_en && starve_cnt==STARVE_LIMIT.
//    A wins if a_valid && !force_b; else B wins if b_valid. Winner ready=1; loser ready=0,
//    except WAW rule below.
//  - WAW rule: a_valid && b_valid && a_wa==b_wa && a_wa!=0 && A wins -> b_ready=1 too; B's
//    write is discarded (A is the younger result). No rf write for B, starve_cnt cleared.
//  - x0 rule: a source with valid && wa==0 is accepted (ready=1) in the same cycle without
//    consuming the port; it never counts as a grant and cannot block the other source.
//  - Latency: accepted write appears on rf_we/rf_wa/rf_wd exactly 1 cycle after handshake;
//    cycle with no granted nonzero write -> rf_we=0, rf_wa/rf_wd hold previous values.
//  - Throughput: 1 write/cycle; A alone sustains 100%; B alone sustains 100%.
//  - starve_cnt (width clog2(STARVE_LIMIT+1)): ++ when b_valid && b_wa!=0 && !b_ready; cleared
//    when b_ready or !b_valid; saturates at STARVE_LIMIT. b_starved = (starve_cnt==STARVE_LIMIT).
//  - Forced-B cycle: a_ready=0 even if a_valid (A stalls one cycle), counter clears on B grant.
//  - Sources hold valid/wa/wd stable until ready; arbiter does not buffer a rejected request.
// CONFIGURATION
//  RF_WB_STARVE_GUARD_EN defined: starvation counter and forced-B grant as above.
//  Undefined: strict A priority, no counter logic, b_starved tied 0; B may wait indefinitely.
//  WAW and x0 rules present in both builds.
// TESTING
//  1 reset: rstn=0 mid-stream with a_valid=1 -> rf_we=0, outputs 0 immediately; no write after release until new handshake.
//  2 A only: a_valid=1 wa=3 wd=0xDEADBEEF -> a_ready=1; next cycle rf_we=1 rf_wa=3 rf_wd=0xDEADBEEF grant_b=0.
//  3 contention: A wa=5, B wa=6 both valid -> a_ready=1 b_ready=0; A drops -> B written next cycle, grant_b=1.
//  4 WAW: A wa=7 wd=1, B wa=7 wd=2 -> both ready same cycle; only rf_wd=1 written; no later write of 2.
//  5 x0: B wa=0 valid while A wa=4 valid -> both ready; single write rf_wa=4; starve_cnt stays 0.
//  6 guard (EN, LIMIT=4): A valid every cycle, B wa=9 -> b_starved=1 after 4 denials; cycle 5 b_ready=1,
//    a_ready=0, rf_wa=9 next cycle; without macro B never granted while A valid.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the pipeline writeback (A) and a long-latency unit (B) onto the single register-file write port.
// Define RF_WB_STARVE_GUARD_EN to add the port-B anti-starvation counter with forced grant.
module rf_wb_arbiter #(
  parameter int unsigned AW           = 5,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_wa,
  input  logic [DW-1:0] a_wd,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_wa,
  input  logic [DW-1:0] b_wd,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          grant_b,
  output logic          b_starved
);

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("rf_wb_arbiter: STARVE_LIMIT must be at least 1");
  end

  // Handshake: a request transfers in any cycle where valid && ready; ready is
  // combinational from valid/address/starve state only, never from rf_* outputs.
  logic a_live, b_live;
  logic force_b;
  logic a_win, b_win, waw;

  // Writes to x0 are accepted immediately and never occupy the port.
  assign a_live = a_valid && (a_wa != '0);
  assign b_live = b_valid && (b_wa != '0);

  assign a_win = a_live && !force_b;
  assign b_win = b_live && !a_win;
  // Same destination as the winning A write: B's older result is dropped.
  assign waw   = a_win && b_live && (b_wa == a_wa);

  assign a_ready = (a_valid && (a_wa == '0)) || a_win;
  assign b_ready = (b_valid && (b_wa == '0)) || b_win || waw;

`ifdef RF_WB_STARVE_GUARD_EN
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] LIMIT_C = SCW'(STARVE_LIMIT);

  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic           b_starved_q;

  assign force_b = b_live && (starve_cnt_q == LIMIT_C);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!b_valid || b_ready) begin
      starve_cnt_d = '0;
    end else if (b_live && (starve_cnt_q != LIMIT_C)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt_q <= '0;
      b_starved_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      b_starved_q  <= (starve_cnt_d == LIMIT_C);
    end
  end

  assign b_starved = b_starved_q;
`else
  assign force_b   = 1'b0;
  assign b_starved = 1'b0;
`endif

  logic          rf_we_q;
  logic [AW-1:0] rf_wa_q;
  logic [DW-1:0] rf_wd_q;
  logic          grant_b_q;

  // Address/data hold their last value when no write is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we_q   <= 1'b0;
      rf_wa_q   <= '0;
      rf_wd_q   <= '0;
      grant_b_q <= 1'b0;
    end else begin
      rf_we_q   <= a_win || b_win;
      grant_b_q <= b_win;
      if (a_win) begin
        rf_wa_q <= a_wa;
        rf_wd_q <= a_wd;
      end else if (b_win) begin
        rf_wa_q <= b_wa;
        rf_wd_q <= b_wd;
      end
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wd   = rf_wd_q;
  assign grant_b = grant_b_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic against a rule-level reference model. Follows RF_WB_STARVE_GUARD_EN.
module tb_rf_wb_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
`ifdef RF_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk, rstn;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_wa, b_wa, rf_wa;
  logic [DW-1:0] a_wd, b_wd, rf_wd;
  logic          rf_we, grant_b, b_starved;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_ready(a_ready), .a_wa(a_wa), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .grant_b(grant_b), .b_starved(b_starved)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: architectural register-file port view
  int                    m_cnt;
  logic                  m_we, m_gb;
  logic [AW-1:0]         m_wa;
  logic [DW-1:0]         m_wd;
  logic [AW+DW-1:0]      exp_q[$];
  logic                  last_ar, last_br, dut_ar, dut_br;

  task automatic model_reset();
    m_cnt = 0; m_we = 1'b0; m_gb = 1'b0; m_wa = '0; m_wd = '0;
    exp_q.delete();
  endtask

  // driver: one cycle, entered and left at posedge+1
  task automatic step(input logic av, input logic [AW-1:0] awa, input logic [DW-1:0] awd,
                      input logic bv, input logic [AW-1:0] bwa, input logic [DW-1:0] bwd);
    logic a_real, b_real, forced, win_a, win_b;
    logic [AW+DW-1:0] exp_w;
    a_valid = av; a_wa = awa; a_wd = awd;
    b_valid = bv; b_wa = bwa; b_wd = bwd;
    a_real = av && (awa != 0);
    b_real = bv && (bwa != 0);
    forced = GUARD && (m_cnt == LIMIT) && b_real;
    win_a  = a_real && !forced;
    win_b  = b_real && !win_a;
    last_ar = (av && awa == 0) || win_a;
    last_br = (bv && bwa == 0) || win_b || (win_a && b_real && bwa == awa);
    #4;
    dut_ar = a_ready;
    dut_br = b_ready;
    check("a_ready", a_ready, last_ar);
    check("b_ready", b_ready, last_br);
    if (GUARD) begin
      if (!bv || last_br) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
    end
    m_we = win_a || win_b;
    m_gb = win_b;
    if (win_a) begin m_wa = awa; m_wd = awd; end
    else if (win_b) begin m_wa = bwa; m_wd = bwd; end
    if (m_we) exp_q.push_back({m_wa, m_wd});
    @(posedge clk);
    #1;
    check("rf_we", rf_we, m_we);
    check("grant_b", grant_b, m_gb);
    check("b_starved", b_starved, (m_cnt == LIMIT));
    if (m_we) begin
      exp_w = exp_q.pop_front();
      check("rf_write", {rf_wa, rf_wd}, exp_w);
    end else begin
      check("rf_hold", {rf_wa, rf_wd}, {m_wa, m_wd});
    end
  endtask

  typedef struct {
    logic av; logic [AW-1:0] awa; logic [DW-1:0] awd;
    logic bv; logic [AW-1:0] bwa; logic [DW-1:0] bwd;
    logic ar; logic br; logic we; logic [AW-1:0] wa; logic [DW-1:0] wd; logic gb;
  } vec_t;

  vec_t vecs[10];

  logic          pa, pb;
  logic [AW-1:0] ra_wa, rb_wa;
  logic [DW-1:0] ra_wd, rb_wd;

  initial begin
    vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 5'd5,  32'h55,       1'b1, 5'd6,  32'h66,       1'b1, 1'b0, 1'b1, 5'd5,  32'h55,       1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h66,       1'b0, 1'b1, 1'b1, 5'd6,  32'h66,       1'b1};
    vecs[3] = '{1'b1, 5'd7,  32'h1,        1'b1, 5'd7,  32'h2,        1'b1, 1'b1, 1'b1, 5'd7,  32'h1,        1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd7,  32'h1,        1'b0};
    vecs[5] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd0,  32'h99,       1'b1, 1'b1, 1'b1, 5'd4,  32'h44,       1'b0};
    vecs[6] = '{1'b1, 5'd0,  32'h11,       1'b1, 5'd8,  32'h88,       1'b1, 1'b1, 1'b1, 5'd8,  32'h88,       1'b1};
    vecs[7] = '{1'b1, 5'd0,  32'h12,       1'b1, 5'd0,  32'h13,       1'b1, 1'b1, 1'b0, 5'd8,  32'h88,       1'b0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
    vecs[9] = '{1'b1, 5'd31, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'h0,        1'b0};

    rstn = 1'b0;
    a_valid = 1'b0; a_wa = '0; a_wd = '0;
    b_valid = 1'b0; b_wa = '0; b_wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_addr_data", {rf_wa, rf_wd}, '0);
    check("reset_grant_b", grant_b, 1'b0);
    check("reset_b_starved", b_starved, 1'b0);
    rstn = 1'b1;

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].av, vecs[i].awa, vecs[i].awd, vecs[i].bv, vecs[i].bwa, vecs[i].bwd);
      check($sformatf("vec%0d_a_ready", i), dut_ar, vecs[i].ar);
      check($sformatf("vec%0d_b_ready", i), dut_br, vecs[i].br);
      check($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].we);
      check($sformatf("vec%0d_rf_wa", i), rf_wa, vecs[i].wa);
      check($sformatf("vec%0d_rf_wd", i), rf_wd, vecs[i].wd);
      check($sformatf("vec%0d_grant_b", i), grant_b, vecs[i].gb);
      check($sformatf("vec%0d_b_starved", i), b_starved, 1'b0);
    end

    // mid-stream asynchronous reset with A still presenting
    a_valid = 1'b1; a_wa = 5'd3; a_wd = 32'hCAFEF00D;
    #2 rstn = 1'b0;
    #1;
    check("async_reset_rf_we", rf_we, 1'b0);
    check("async_reset_addr_data", {rf_wa, rf_wd}, '0);
    check("async_reset_grant_b", grant_b, 1'b0);
    @(posedge clk);
    #1;
    check("in_reset_rf_we", rf_we, 1'b0);
    a_valid = 1'b0;
    rstn = 1'b1;
    model_reset();
    step(1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check("post_reset_no_write", rf_we, 1'b0);

    // starvation scenario: A valid every cycle, B targets x9
    for (int i = 0; i < LIMIT; i++) begin
      step(1'b1, 5'd3, 32'hA0A0, 1'b1, 5'd9, 32'h9999);
      check("starve_b_denied", dut_br, 1'b0);
    end
`ifdef RF_WB_STARVE_GUARD_EN
    check("starve_flag_set", b_starved, 1'b1);
    step(1'b1, 5'd3, 32'hA0A0, 1'b1, 5'd9, 32'h9999);
    check("forced_b_ready", dut_br, 1'b1);
    check("forced_a_ready", dut_ar, 1'b0);
    check("forced_rf_wa", rf_wa, 5'd9);
    check("forced_grant_b", grant_b, 1'b1);
    check("forced_flag_clear", b_starved, 1'b0);
    step(1'b1, 5'd3, 32'hA0A0, 1'b0, '0, '0);
    check("a_after_forced", rf_wa, 5'd3);
`else
    check("no_guard_flag", b_starved, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd3, 32'hA0A0, 1'b1, 5'd9, 32'h9999);
      check("no_guard_b_waits", dut_br, 1'b0);
    end
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h9999);
    check("b_after_a_drops", rf_wa, 5'd9);
    check("b_after_a_drops_gb", grant_b, 1'b1);
`endif

    // B alone sustains one write per cycle
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 5'(i + 10), DW'(i * 32'h1111));
      check("b_stream_we", rf_we, 1'b1);
    end

    // randomized traffic honouring hold-until-ready
    pa = 1'b0; pb = 1'b0;
    ra_wa = '0; rb_wa = '0; ra_wd = '0; rb_wd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && ($urandom_range(0, 3) != 0)) begin
        pa = 1'b1; ra_wa = 5'($urandom_range(0, 7)); ra_wd = $urandom;
      end
      if (!pb && ($urandom_range(0, 2) != 0)) begin
        pb = 1'b1; rb_wa = 5'($urandom_range(0, 7)); rb_wd = $urandom;
      end
      step(pa, ra_wa, ra_wd, pb, rb_wa, rb_wd);
      if (last_ar) pa = 1'b0;
      if (last_br) pb = 1'b0;
    end
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
